alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter that time-shares the single existing `Alu` instance between two requesters, such as the pipeline EX stage and the debug unit. It accepts operand/opcode requests over a valid/ready handshake and selects one requester per cycle, round-robin by default. It drives the selected operands into `Alu` and captures `o_alu`/`o_zero` into a per-port response register. Each response is held until that port's consumer accepts it.

## Interface
- `NB_DATA`, 32, operand/result width (passed to `Alu`)
- `NB_OPE`, 4, opcode width (`i_ope_sel` of `Alu`)
- `i_clk`  in  1  clock, all state on rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_pN_valid`  in  1  request valid, port N ∈ {0,1}
- `o_pN_ready`  out  1  request accepted this cycle (equals grant N)
- `i_pN_a`, `i_pN_b`  in  NB_DATA  operands (map to `i_data_a`/`i_data_b`; shift amount on `a`, shifted value on `b`)
- `i_pN_ope`  in  NB_OPE  ALU opcode (AND=0, OR=1, ADD=2, XOR=3, SUB=6, SLT=7, SLL=8, SRL=9, SRA=10, NOR=12, JAL=13, LUI=14)
- `o_pN_rvalid`  out  1  response valid
- `i_pN_rready`  in  1  response consumed
- `o_pN_result`  out  NB_DATA  registered `o_alu`
- `o_pN_zero`  out  1  registered `o_zero`

## Operation
- Eligibility: `elig_N = i_pN_valid && (!o_pN_rvalid || i_pN_rready)`. A port with an unconsumed response is not eligible. Draining the response in the same cycle makes the port eligible.
- Grant: at most one port per cycle.
  - Only one port eligible: grant it.
  - Both eligible: grant the port that is not `last_grant`.
- `last_grant` (1 bit) updates to the granted port on any grant. It holds when there is no grant.
- ALU input mux: selects the granted port's a/b/ope. With no grant it selects port 0's inputs; the result is discarded.
- On grant N at edge: `o_pN_result <= o_alu`, `o_pN_zero <= o_zero`, `o_pN_rvalid <= 1`.
- Response register N without a new grant:
  - `rvalid && rready` → `o_pN_rvalid <= 0`; data holds its last value.
  - Otherwise holds.
- A grant and `rready` on the same port in the same cycle load the new result; `rvalid` stays 1.
- Opcodes outside the list are forwarded unchanged; the response is whatever `Alu` produces (undefined opcodes return 0). The arbiter never rejects on opcode.
- Requester contract: a/b/ope are held stable while `valid && !ready`. The arbiter does not check this.

## Timing
- Reset (`i_rst` = 1 at edge):
  - `o_pN_rvalid` = 0 and `o_pN_result` = 0 on both ports.
  - `o_pN_zero` = 1, matching `Alu` with a zero result.
  - `last_grant` = 1, so port 0 wins the first conflict.
  - Any in-flight request is dropped. `o_pN_ready` is 0 during reset.
- Latency: request accepted in cycle T → `o_pN_rvalid` high from cycle T+1.
- Throughput: 1 op/cycle total. Each port can sustain 1 op/cycle while its `rready` is held high.
- `o_pN_ready` is combinational from `i_p0_valid`, `i_p1_valid`, `o_pN_rvalid`, `i_pN_rready` and `last_grant`. It has no path from operand data.
- Result path is combinational through `Alu` to the response flops within one cycle.
- Under sustained dual contention, grants strictly alternate 0,1,0,1…

## Configuration
- `ALU_SHARE_RR_EN` defined: round-robin as above.
- `ALU_SHARE_RR_EN` undefined: fixed priority, port 0 always wins a conflict.
  - `last_grant` is removed.
  - Port 1 may starve. This build is for the debug-on-port-1 configuration only.

## Structure
- Shared package `alu_pkg`: opcode localparams (SLL, SRL, SRA, ADD, SUB, AND, OR, XOR, NOR, SLT, JAL, LUI), `NB_DATA`, `NB_OPE`. Both `Alu` and this block use it.
- Sub-module `alu_rr_arb2`: inputs `elig[1:0]`, output one-hot `grant[1:0]`, holds `last_grant`. Fixed-priority variant selected by `ALU_SHARE_RR_EN`.
- Top: instantiates `alu_rr_arb2`, the operand mux, one `Alu`, and two response registers.

## Test plan
- Port 0 ADD a=255, b=1, p1 idle, rready=1: ready0 in same cycle; next cycle rvalid0=1, result0=256, zero0=0.
- Port 1 SUB a=255, b=255: result1=0, zero1=1; port 0 rvalid unchanged.
- Both valid each cycle after reset, p0 AND 0xffffffff & 0x2, p1 OR 0xf00 | 0x0f0, rready=1: grants 0,1,0,1.
  - Results: result0=0x2, result1=0xff0.
  - With the macro undefined: grant 0 every cycle, p1 never ready.
- Port 0 rready=0 after SLT a=4, b=5 (result 1): p0 holds rvalid with result 1 and ready0 stays 0. Port 1 SRA a=4, b=0xe0000080 is served meanwhile (result 0xfe000008). Raising rready0 with valid0 high reloads in that cycle.
- Same-cycle drain and grant on port 0, LUI b=0x19fff: rvalid0 stays 1, result0=0x9fff0000.
- Assert `i_rst` for one cycle while both ports hold responses and requests: next cycle both rvalid=0, results 0, zero 1. First conflict after reset grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths and opcode encodings used by Alu and alu_share_arb.
package alu_pkg;
   localparam int unsigned NB_DATA = 32;
   localparam int unsigned NB_OPE  = 4;

   localparam logic [3:0] AND = 4'd0;
   localparam logic [3:0] OR  = 4'd1;
   localparam logic [3:0] ADD = 4'd2;
   localparam logic [3:0] XOR = 4'd3;
   localparam logic [3:0] SUB = 4'd6;
   localparam logic [3:0] SLT = 4'd7;
   localparam logic [3:0] SLL = 4'd8;
   localparam logic [3:0] SRL = 4'd9;
   localparam logic [3:0] SRA = 4'd10;
   localparam logic [3:0] NOR = 4'd12;
   localparam logic [3:0] JAL = 4'd13;
   localparam logic [3:0] LUI = 4'd14;
endpackage

// File: rtl/Alu.sv
// Combinational ALU: shift amount on a, shifted value on b; undefined opcodes return 0.
module Alu
   import alu_pkg::*;
#(
   parameter int unsigned NB_DATA = alu_pkg::NB_DATA,
   parameter int unsigned NB_OPE  = alu_pkg::NB_OPE
) (
   input  logic [NB_DATA-1:0] i_data_a,
   input  logic [NB_DATA-1:0] i_data_b,
   input  logic [NB_OPE-1:0]  i_ope_sel,
   output logic [NB_DATA-1:0] o_alu,
   output logic               o_zero
);
   localparam int unsigned NB_SHAMT = $clog2(NB_DATA);

   logic [NB_SHAMT-1:0] shamt;
   assign shamt = i_data_a[NB_SHAMT-1:0];

   always_comb begin
      o_alu = '0;
      case (i_ope_sel)
         NB_OPE'(AND): o_alu = i_data_a & i_data_b;
         NB_OPE'(OR):  o_alu = i_data_a | i_data_b;
         NB_OPE'(ADD): o_alu = i_data_a + i_data_b;
         NB_OPE'(XOR): o_alu = i_data_a ^ i_data_b;
         NB_OPE'(SUB): o_alu = i_data_a - i_data_b;
         NB_OPE'(SLT): o_alu = NB_DATA'($signed(i_data_a) < $signed(i_data_b));
         NB_OPE'(SLL): o_alu = i_data_b << shamt;
         NB_OPE'(SRL): o_alu = i_data_b >> shamt;
         NB_OPE'(SRA): o_alu = $signed(i_data_b) >>> shamt;
         NB_OPE'(NOR): o_alu = ~(i_data_a | i_data_b);
         NB_OPE'(JAL): o_alu = i_data_a + NB_DATA'(4);
         NB_OPE'(LUI): o_alu = i_data_b << (NB_DATA / 2);
         default:      o_alu = '0;
      endcase
   end

   assign o_zero = (o_alu == '0);
endmodule

// File: rtl/alu_rr_arb2.sv
// Two-requester grant logic; round-robin with ALU_SHARE_RR_EN defined, else port 0 fixed priority.
module alu_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] elig,
   output logic [1:0] grant
);
`ifdef ALU_SHARE_RR_EN
   logic last_grant;

   // Port 1 as the reset value lets port 0 win the first conflict.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end

   always_comb begin
      grant = elig;
      if (elig == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = i_clk ^ i_rst;

   always_comb begin
      grant = 2'b00;
      if (elig[0]) begin
         grant = 2'b01;
      end else if (elig[1]) begin
         grant = 2'b10;
      end
   end
`endif
endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one Alu between two valid/ready requesters with per-port held responses.
// Arbitration policy selected by ALU_SHARE_RR_EN (round-robin) or fixed priority when undefined.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter int unsigned NB_DATA = alu_pkg::NB_DATA,
   parameter int unsigned NB_OPE  = alu_pkg::NB_OPE
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_p0_valid,
   output logic               o_p0_ready,
   input  logic [NB_DATA-1:0] i_p0_a,
   input  logic [NB_DATA-1:0] i_p0_b,
   input  logic [NB_OPE-1:0]  i_p0_ope,
   output logic               o_p0_rvalid,
   input  logic               i_p0_rready,
   output logic [NB_DATA-1:0] o_p0_result,
   output logic               o_p0_zero,
   input  logic               i_p1_valid,
   output logic               o_p1_ready,
   input  logic [NB_DATA-1:0] i_p1_a,
   input  logic [NB_DATA-1:0] i_p1_b,
   input  logic [NB_OPE-1:0]  i_p1_ope,
   output logic               o_p1_rvalid,
   input  logic               i_p1_rready,
   output logic [NB_DATA-1:0] o_p1_result,
   output logic               o_p1_zero
);
   logic [1:0]         elig;
   logic [1:0]         grant;
   logic [NB_DATA-1:0] alu_a;
   logic [NB_DATA-1:0] alu_b;
   logic [NB_OPE-1:0]  alu_ope;
   logic [NB_DATA-1:0] alu_res;
   logic               alu_zero;

   // A port draining its response this cycle may issue again.
   assign elig[0] = !i_rst && i_p0_valid && (!o_p0_rvalid || i_p0_rready);
   assign elig[1] = !i_rst && i_p1_valid && (!o_p1_rvalid || i_p1_rready);

   alu_rr_arb2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .elig  (elig),
      .grant (grant)
   );

   assign o_p0_ready = grant[0];
   assign o_p1_ready = grant[1];

   assign alu_a   = grant[1] ? i_p1_a   : i_p0_a;
   assign alu_b   = grant[1] ? i_p1_b   : i_p0_b;
   assign alu_ope = grant[1] ? i_p1_ope : i_p0_ope;

   Alu #(
      .NB_DATA (NB_DATA),
      .NB_OPE  (NB_OPE)
   ) u_alu (
      .i_data_a  (alu_a),
      .i_data_b  (alu_b),
      .i_ope_sel (alu_ope),
      .o_alu     (alu_res),
      .o_zero    (alu_zero)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_p0_rvalid <= 1'b0;
         o_p0_result <= '0;
         o_p0_zero   <= 1'b1;
      end else if (grant[0]) begin
         o_p0_rvalid <= 1'b1;
         o_p0_result <= alu_res;
         o_p0_zero   <= alu_zero;
      end else if (o_p0_rvalid && i_p0_rready) begin
         o_p0_rvalid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_p1_rvalid <= 1'b0;
         o_p1_result <= '0;
         o_p1_zero   <= 1'b1;
      end else if (grant[1]) begin
         o_p1_rvalid <= 1'b1;
         o_p1_result <= alu_res;
         o_p1_zero   <= alu_zero;
      end else if (o_p1_rvalid && i_p1_rready) begin
         o_p1_rvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed scenarios then randomized traffic vs. a reference model.
module tb_alu_share_arb;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1, rdy0, rdy1, rr0, rr1, rv0, rv1, z0, z1;
   logic [31:0] a0, b0, a1, b1, res0, res1;
   logic [3:0]  op0, op1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic        zero;
   } rsp_t;

   rsp_t q0[$];
   rsp_t q1[$];

   bit m_occ0, m_occ1, m_lg;
   bit g0, g1;

   always #5 clk = ~clk;

   alu_share_arb dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_p0_valid  (v0),
      .o_p0_ready  (rdy0),
      .i_p0_a      (a0),
      .i_p0_b      (b0),
      .i_p0_ope    (op0),
      .o_p0_rvalid (rv0),
      .i_p0_rready (rr0),
      .o_p0_result (res0),
      .o_p0_zero   (z0),
      .i_p1_valid  (v1),
      .o_p1_ready  (rdy1),
      .i_p1_a      (a1),
      .i_p1_b      (b1),
      .i_p1_ope    (op1),
      .o_p1_rvalid (rv1),
      .i_p1_rready (rr1),
      .o_p1_result (res1),
      .o_p1_zero   (z1)
   );

   function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
      int sh;
      sh = int'(a % 32);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a ^ b;
         4'd6:    return a - b;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:    return b << sh;
         4'd9:    return b >> sh;
         4'd10:   return (b[31] && sh != 0) ? ((b >> sh) | ~(32'hffffffff >> sh)) : (b >> sh);
         4'd12:   return ~(a | b);
         4'd13:   return a + 32'd4;
         4'd14:   return b * 32'h10000;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: compare handshake outputs with the model, then advance the model over the edge.
   task automatic step();
      bit e0, e1;
      rsp_t r;
      @(negedge clk);
      check("rvalid0", 32'(rv0), 32'(m_occ0));
      check("rvalid1", 32'(rv1), 32'(m_occ1));
      e0 = !rst && v0 && (!m_occ0 || rr0);
      e1 = !rst && v1 && (!m_occ1 || rr1);
      g0 = e0;
      g1 = e1;
      if (e0 && e1) begin
`ifdef ALU_SHARE_RR_EN
         g0 = m_lg;
         g1 = !m_lg;
`else
         g1 = 1'b0;
`endif
      end
      check("ready0", 32'(rdy0), 32'(g0));
      check("ready1", 32'(rdy1), 32'(g1));
      if (rst) begin
         m_occ0 = 0;
         m_occ1 = 0;
         m_lg   = 1;
         q0.delete();
         q1.delete();
      end else begin
         if (g0) begin
            r.res = ref_alu(a0, b0, op0);
            r.zero = (r.res == 32'd0);
            q0.push_back(r);
            m_occ0 = 1;
         end else if (m_occ0 && rr0) begin
            m_occ0 = 0;
         end
         if (g1) begin
            r.res = ref_alu(a1, b1, op1);
            r.zero = (r.res == 32'd0);
            q1.push_back(r);
            m_occ1 = 1;
         end else if (m_occ1 && rr1) begin
            m_occ1 = 0;
         end
         if (g0 || g1) m_lg = g1;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: each response consumed at the coming edge is compared against the scoreboard.
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && rv0 && rr0) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p0_unexpected: got response %h, expected none", res0);
         end else begin
            e = q0.pop_front();
            check("p0_result", res0, e.res);
            check("p0_zero", 32'(z0), 32'(e.zero));
         end
      end
      if (!rst && rv1 && rr1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL p1_unexpected: got response %h, expected none", res1);
         end else begin
            e = q1.pop_front();
            check("p1_result", res1, e.res);
            check("p1_zero", 32'(z1), 32'(e.zero));
         end
      end
   end

   task automatic set0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr);
      v0 = v; op0 = op; a0 = a; b0 = b; rr0 = rr;
   endtask

   task automatic set1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rr);
      v1 = v; op1 = op; a1 = a; b1 = b; rr1 = rr;
   endtask

   logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};

   initial begin
      rst = 1'b1;
      set0(1'b1, ADD, 32'd1, 32'd2, 1'b0);
      set1(1'b1, ADD, 32'd3, 32'd4, 1'b0);
      m_lg = 1;
      #1;
      step();
      step();
      rst = 1'b0;
      check("reset_result0", res0, 32'd0);
      check("reset_zero1", 32'(z1), 32'd1);

      // Port 0 ADD with port 1 idle
      set0(1'b1, ADD, 32'd255, 32'd1, 1'b1);
      set1(1'b0, ADD, 32'd0, 32'd0, 1'b1);
      step();
      check("add_result0", res0, 32'd256);
      check("add_zero0", 32'(z0), 32'd0);

      // Port 1 SUB to zero while port 0 holds its response
      set0(1'b0, ADD, 32'd0, 32'd0, 1'b0);
      set1(1'b1, SUB, 32'd255, 32'd255, 1'b1);
      step();
      check("sub_result1", res1, 32'd0);
      check("sub_zero1", 32'(z1), 32'd1);
      check("p0_hold_rvalid", 32'(rv0), 32'd1);

      // Sustained contention
      set0(1'b1, AND, 32'hffffffff, 32'h2, 1'b1);
      set1(1'b1, OR, 32'hf00, 32'h0f0, 1'b1);
      repeat (4) step();
      check("contend_result0", res0, 32'h2);
`ifdef ALU_SHARE_RR_EN
      check("contend_result1", res1, 32'hff0);
`else
      check("contend_result1", res1, 32'h0);
`endif

      // Port 0 stalled on its response while port 1 is served
      set0(1'b1, SLT, 32'd4, 32'd5, 1'b1);
      set1(1'b0, ADD, 32'd0, 32'd0, 1'b1);
      step();
      set0(1'b1, ADD, 32'd7, 32'd8, 1'b0);
      set1(1'b1, SRA, 32'd4, 32'he0000080, 1'b1);
      step();
      step();
      check("slt_hold_result0", res0, 32'd1);
      check("sra_result1", res1, 32'hfe000008);
      rr0 = 1'b1;
      v1 = 1'b0;
      step();
      check("reload_result0", res0, 32'd15);

      // Same-cycle drain and grant on port 0
      set0(1'b1, LUI, 32'd0, 32'h19fff, 1'b1);
      step();
      check("lui_rvalid0", 32'(rv0), 32'd1);
      check("lui_result0", res0, 32'h9fff0000);

      // Reset with both responses held and requests pending
      set0(1'b1, ADD, 32'd1, 32'd1, 1'b0);
      set1(1'b1, ADD, 32'd2, 32'd2, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_rvalid0", 32'(rv0), 32'd0);
      check("rst_rvalid1", 32'(rv1), 32'd0);
      check("rst_result0", res0, 32'd0);
      check("rst_result1", res1, 32'd0);
      check("rst_zero0", 32'(z0), 32'd1);
      check("rst_zero1", 32'(z1), 32'd1);
      rr0 = 1'b1;
      rr1 = 1'b1;
      step();
      check("post_rst_grant0", res0, 32'd2);

      // Randomized traffic honouring the hold-while-stalled contract
      for (int i = 0; i < 400; i++) begin
         if (!(v0 && !g0)) begin
            v0 = ($urandom_range(0, 3) != 0);
            op0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 11)];
            a0 = $urandom;
            b0 = $urandom;
         end
         if (!(v1 && !g1)) begin
            v1 = ($urandom_range(0, 3) != 0);
            op1 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 11)];
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
         end
         rr0 = ($urandom_range(0, 3) != 0);
         rr1 = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 149) == 0);
         step();
      end

      // Drain everything still held
      rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      rr0 = 1'b1;
      rr1 = 1'b1;
      repeat (3) step();
      check("drain_q0", 32'(q0.size()), 32'd0);
      check("drain_q1", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
